// File: rtl/gate_array_pkg.sv
// Shared definitions for the gate array filter: gate mode encodings,
// per-channel filter states and the gate-function helper.
package gate_array_pkg;

  // Gate function applied to every channel slice.
  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_NAND = 2'b01,
    MODE_OR   = 2'b10,
    MODE_NOR  = 2'b11
  } mode_e;

  // Per-channel filter state.
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } filt_state_e;

  // Width of the per-cycle update popcount (up to 16 channels).
  localparam int POP_W = 5;

  // Combine precomputed AND/OR reductions according to the selected mode.
  function automatic logic gate_apply(input mode_e mode, input logic all_ones,
                                      input logic any_one);
    logic res;
    case (mode)
      MODE_AND:  res = all_ones;
      MODE_NAND: res = ~all_ones;
      MODE_OR:   res = any_one;
      MODE_NOR:  res = ~any_one;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_array_filt_if.sv
// Bus interface of the gate array filter: sampled data/mode inputs,
// control strobes and the filtered outputs.
interface gate_array_filt_if #(
  parameter int CHANNELS = 3,
  parameter int INPUTS   = 3,
  parameter int CNT_W    = 8
);
  logic [CHANNELS*INPUTS-1:0] in_data;
  logic [1:0]                 in_mode;
  logic                       in_en;
  logic                       in_cnt_clr;
  logic [CHANNELS-1:0]        out_y;
  logic [CHANNELS-1:0]        out_chg;
  logic [CNT_W-1:0]           out_evt_cnt;

  modport master (
    output in_data, in_mode, in_en, in_cnt_clr,
    input  out_y, out_chg, out_evt_cnt
  );

  modport slave (
    input  in_data, in_mode, in_en, in_cnt_clr,
    output out_y, out_chg, out_evt_cnt
  );
endinterface

// File: rtl/gate_filt_ch.sv
// One gate channel: mode reduction of the sampled slice, persistence
// filter (STABLE/PENDING) and the one-cycle change pulse.
module gate_filt_ch
  import gate_array_pkg::*;
#(
  parameter int INPUTS   = 3,
  parameter int FILT_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INPUTS-1:0] i_data,
  input  mode_e             i_mode,
  input  logic              i_en,
  output logic              o_y,
  output logic              o_chg,
  output logic              o_upd
);

  localparam int CW = ($clog2(FILT_LEN + 1) < 1) ? 1 : $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  filt_state_e   r_state;
  filt_state_e   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_y;
  logic          w_y_nxt;
  logic          r_chg;
  logic          w_chg_nxt;
  logic          w_raw;

  assign w_raw = gate_apply(i_mode, &i_data, |i_data);

  // Filter state, count, filtered output and change pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STABLE;
      r_cnt   <= CNT_ZERO;
      r_y     <= 1'b0;
      r_chg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_y     <= w_y_nxt;
      r_chg   <= w_chg_nxt;
    end
  end

  // Next-state logic: a differing raw value must survive FILT_LEN edges;
  // returning to the current output at any point discards the attempt.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_y_nxt     = r_y;
    w_chg_nxt   = 1'b0;
    o_upd       = 1'b0;
    if (i_en) begin
      case (r_state)
        ST_STABLE: begin
          if (w_raw == r_y) begin
            w_cnt_nxt = CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            // FILT_LEN of 1: commit on the first differing edge.
            w_y_nxt   = w_raw;
            w_cnt_nxt = CNT_ZERO;
            w_chg_nxt = 1'b1;
            o_upd     = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_ONE;
            w_state_nxt = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (w_raw == r_y) begin
            w_cnt_nxt   = CNT_ZERO;
            w_state_nxt = ST_STABLE;
          end else if (r_cnt == CNT_LAST) begin
            w_y_nxt     = w_raw;
            w_cnt_nxt   = CNT_ZERO;
            w_chg_nxt   = 1'b1;
            o_upd       = 1'b1;
            w_state_nxt = ST_STABLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end else begin
      // Disabled: everything holds, no pulse.
      w_chg_nxt = 1'b0;
    end
  end

  assign o_y   = r_y;
  assign o_chg = r_chg;

endmodule

// File: rtl/gate_array_filt.sv
// Gate array filter top: samples data/mode every edge, runs CHANNELS
// independent filtered gate channels and counts output changes.
module gate_array_filt
  import gate_array_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int INPUTS   = 3,
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 8
) (
  input logic               clk,
  input logic               rst_n,
  gate_array_filt_if.slave  bus
);

  localparam int SUM_W = CNT_W + POP_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CHANNELS*INPUTS-1:0] r_data;
  mode_e                      r_mode;
  logic [CHANNELS-1:0]        w_y;
  logic [CHANNELS-1:0]        w_chg;
  logic [CHANNELS-1:0]        w_upd;
  logic [POP_W-1:0]           w_pop;
  logic [SUM_W-1:0]           w_sum;
  logic [CNT_W-1:0]           w_evt_nxt;
  logic [CNT_W-1:0]           r_evt;

  // Sample register: captures data and mode on every edge, even when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_mode <= MODE_AND;
    end else begin
      r_data <= bus.in_data;
      r_mode <= mode_e'(bus.in_mode);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    gate_filt_ch #(
      .INPUTS   (INPUTS),
      .FILT_LEN (FILT_LEN)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_data (r_data[c*INPUTS +: INPUTS]),
      .i_mode (r_mode),
      .i_en   (bus.in_en),
      .o_y    (w_y[c]),
      .o_chg  (w_chg[c]),
      .o_upd  (w_upd[c])
    );
  end

  // Number of channels committing a new output on this edge.
  always_comb begin
    w_pop = {POP_W{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      w_pop = w_pop + {{(POP_W-1){1'b0}}, w_upd[c]};
    end
  end

  // Saturating add of this edge's updates onto the event count.
  always_comb begin
    w_sum = {{POP_W{1'b0}}, r_evt} + {{(SUM_W-POP_W){1'b0}}, w_pop};
    if (w_sum > {{POP_W{1'b0}}, CNT_MAX}) begin
      w_evt_nxt = CNT_MAX;
    end else begin
      w_evt_nxt = w_sum[CNT_W-1:0];
    end
  end

  // Event counter: clear wins over same-edge increments; holds when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt <= '0;
    end else if (bus.in_cnt_clr) begin
      r_evt <= '0;
    end else if (bus.in_en) begin
      r_evt <= w_evt_nxt;
    end else begin
      r_evt <= r_evt;
    end
  end

  assign bus.out_y       = w_y;
  assign bus.out_chg     = w_chg;
  assign bus.out_evt_cnt = r_evt;

endmodule

// File: tb/tb_gate_array_filt.sv
// Directed testbench for gate_array_filt: default instance (3x3, FILT_LEN 4,
// CNT_W 8) plus a CNT_W=2 instance for counter saturation.
module tb_gate_array_filt;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  gate_array_filt_if #(.CHANNELS(3), .INPUTS(3), .CNT_W(8)) bus_a ();
  gate_array_filt_if #(.CHANNELS(3), .INPUTS(3), .CNT_W(2)) bus_b ();

  gate_array_filt #(.CHANNELS(3), .INPUTS(3), .FILT_LEN(4), .CNT_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  gate_array_filt #(.CHANNELS(3), .INPUTS(3), .FILT_LEN(4), .CNT_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_gate(input logic [1:0] m, input logic [2:0] d);
    case (m)
      2'b00:   return &d;
      2'b01:   return ~&d;
      2'b10:   return |d;
      default: return ~|d;
    endcase
  endfunction

  initial begin
    logic [2:0] v0, v1, v2;
    logic [2:0] ey;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_a.in_data = 9'h000; bus_a.in_mode = 2'b00; bus_a.in_en = 1'b1; bus_a.in_cnt_clr = 1'b0;
    bus_b.in_data = 9'h000; bus_b.in_mode = 2'b00; bus_b.in_en = 1'b1; bus_b.in_cnt_clr = 1'b0;
    #12;
    chk("rst_y",   32'(bus_a.out_y),       32'h0);
    chk("rst_chg", 32'(bus_a.out_chg),     32'h0);
    chk("rst_cnt", 32'(bus_a.out_evt_cnt), 32'h0);
    rst_n = 1'b1;
    tick(); tick(); tick();

    // Glitch: 111 sampled three times, then 110 -> discarded.
    bus_a.in_data = 9'b000_000_111;
    tick(); tick(); tick();
    bus_a.in_data = 9'b000_000_110;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("glitch_y",   32'(bus_a.out_y),   32'h0);
      chk("glitch_chg", 32'(bus_a.out_chg), 32'h0);
    end
    chk("glitch_cnt", 32'(bus_a.out_evt_cnt), 32'h0);

    // Persistent 111 on ch0: output rises 4 edges after sampling.
    bus_a.in_data = 9'b000_000_111;
    tick();
    tick(); tick(); tick();
    chk("lat_y_early", 32'(bus_a.out_y), 32'h0);
    tick();
    chk("lat_y",   32'(bus_a.out_y),       32'h1);
    chk("lat_chg", 32'(bus_a.out_chg),     32'h1);
    chk("lat_cnt", 32'(bus_a.out_evt_cnt), 32'h1);
    tick();
    chk("lat_chg_off", 32'(bus_a.out_chg), 32'h0);
    chk("lat_y_hold",  32'(bus_a.out_y),   32'h1);

    // Truth table sweep: every mode, 8 vectors, distinct per channel.
    for (int m = 0; m < 4; m++) begin
      for (int v = 0; v < 8; v++) begin
        v0 = 3'(v); v1 = 3'(v + 3); v2 = 3'(v + 5);
        bus_a.in_mode = 2'(m);
        bus_a.in_data = {v2, v1, v0};
        for (int t = 0; t < 6; t++) tick();
        ey = {exp_gate(2'(m), v2), exp_gate(2'(m), v1), exp_gate(2'(m), v0)};
        chk("truth_y", 32'(bus_a.out_y), 32'(ey));
      end
    end

    // Back to AND / zeros, then clear the counter.
    bus_a.in_mode = 2'b00; bus_a.in_data = 9'h000;
    for (int t = 0; t < 6; t++) tick();
    chk("idle_y", 32'(bus_a.out_y), 32'h0);
    bus_a.in_cnt_clr = 1'b1;
    tick();
    bus_a.in_cnt_clr = 1'b0;
    chk("clr_cnt", 32'(bus_a.out_evt_cnt), 32'h0);

    // NAND with zeros: all three rise together.
    bus_a.in_mode = 2'b01;
    tick();
    tick(); tick(); tick();
    chk("nand_y_early", 32'(bus_a.out_y), 32'h0);
    tick();
    chk("nand_y",   32'(bus_a.out_y),       32'h7);
    chk("nand_chg", 32'(bus_a.out_chg),     32'h7);
    chk("nand_cnt", 32'(bus_a.out_evt_cnt), 32'h3);
    tick();
    chk("nand_chg_off", 32'(bus_a.out_chg), 32'h0);

    // Enable freeze in the middle of a pending change.
    bus_a.in_mode = 2'b00;
    tick(); tick(); tick();
    bus_a.in_en = 1'b0;
    tick(); tick();
    chk("frz_y",   32'(bus_a.out_y),       32'h7);
    chk("frz_chg", 32'(bus_a.out_chg),     32'h0);
    chk("frz_cnt", 32'(bus_a.out_evt_cnt), 32'h3);
    bus_a.in_en = 1'b1;
    tick();
    chk("frz_y_rem", 32'(bus_a.out_y), 32'h7);
    tick();
    chk("frz_y_done",   32'(bus_a.out_y),       32'h0);
    chk("frz_chg_done", 32'(bus_a.out_chg),     32'h7);
    chk("frz_cnt_done", 32'(bus_a.out_evt_cnt), 32'h6);

    // Mid-run reset with a pending change.
    bus_a.in_data = 9'h1FF;
    for (int t = 0; t < 6; t++) tick();
    chk("pre_rst_y",   32'(bus_a.out_y),       32'h7);
    chk("pre_rst_cnt", 32'(bus_a.out_evt_cnt), 32'h9);
    bus_a.in_data = 9'h000;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_y",   32'(bus_a.out_y),       32'h0);
    chk("mid_rst_chg", 32'(bus_a.out_chg),     32'h0);
    chk("mid_rst_cnt", 32'(bus_a.out_evt_cnt), 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) tick();
    chk("post_rst_y",   32'(bus_a.out_y),       32'h0);
    chk("post_rst_cnt", 32'(bus_a.out_evt_cnt), 32'h0);

    // Reset with NAND and zero inputs: output rises only through filtering.
    #2;
    rst_n = 1'b0;
    bus_a.in_mode = 2'b01;
    @(posedge clk); #3;
    rst_n = 1'b1;
    tick();
    tick(); tick(); tick();
    chk("nand_rst_early", 32'(bus_a.out_y), 32'h0);
    tick();
    chk("nand_rst_y",   32'(bus_a.out_y),       32'h7);
    chk("nand_rst_cnt", 32'(bus_a.out_evt_cnt), 32'h3);

    // CNT_W=2 instance: saturation at 3 over six toggles of ch0.
    for (int k = 1; k <= 6; k++) begin
      bus_b.in_data = (k % 2 == 1) ? 9'b000_000_111 : 9'h000;
      for (int t = 0; t < 6; t++) tick();
      chk("sat_cnt", 32'(bus_b.out_evt_cnt), (k < 3) ? 32'(k) : 32'h3);
    end
    // Clear on the very edge of a pulse.
    bus_b.in_data = 9'b000_000_111;
    tick();
    tick(); tick(); tick();
    bus_b.in_cnt_clr = 1'b1;
    tick();
    bus_b.in_cnt_clr = 1'b0;
    chk("clr_pulse_chg", 32'(bus_b.out_chg),     32'h1);
    chk("clr_pulse_y",   32'(bus_b.out_y),       32'h1);
    chk("clr_pulse_cnt", 32'(bus_b.out_evt_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
